// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, requester
// IDs, read-latency bounds and the round-robin rotation helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // Requester IDs double as bit positions in the request vector.
  typedef enum logic [1:0] {
    REQ_FET = 2'd0,
    REQ_LD  = 2'd1,
    REQ_ST  = 2'd2
  } req_id_e;

  localparam int unsigned NUM_REQ    = 3;
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;

  // Rotation order fetch -> load -> store -> fetch.
  function automatic req_id_e next_id(input req_id_e id);
    case (id)
      REQ_FET: next_id = REQ_LD;
      REQ_LD:  next_id = REQ_ST;
      default: next_id = REQ_FET;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 3-way request picker.
//   Default build  : fixed priority store > load > fetch.
//   MEM_ARB_RR_EN  : round-robin; ptr_i names the requester with the highest
//                    priority this round, the others follow in rotation order.
// Ports:
//   req_i   [2:0]  request vector indexed by req_id_e
//   ptr_i          (MEM_ARB_RR_EN only) highest-priority requester
//   valid_o        at least one request present
//   id_o           winning requester
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
`ifdef MEM_ARB_RR_EN
  input  req_id_e            ptr_i,
`endif
  output logic               valid_o,
  output req_id_e            id_o
);

`ifdef MEM_ARB_RR_EN
  req_id_e cand0, cand1, cand2;

  assign cand0 = ptr_i;
  assign cand1 = next_id(ptr_i);
  assign cand2 = next_id(cand1);
`endif

  // NOTE: every output of a combinational block is given a default before
  // any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    valid_o = |req_i;
    id_o    = REQ_FET;
`ifdef MEM_ARB_RR_EN
    // Lowest priority evaluated first so the highest one overrides it.
    if (req_i[cand2]) id_o = cand2;
    if (req_i[cand1]) id_o = cand1;
    if (req_i[cand0]) id_o = cand0;
`else
    if (req_i[REQ_ST])      id_o = REQ_ST;
    else if (req_i[REQ_LD]) id_o = REQ_LD;
    else                    id_o = REQ_FET;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter for fetch, load and store requesters.
// One transaction at a time: IDLE arbitrates, ACCESS strobes the memory for
// one cycle, reads then WAIT RD_LAT cycles, RESP pulses done and returns.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration
// (default is fixed priority store > load > fetch, no pointer register).
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   fet_req_i/fet_addr_i             fetch read request
//   ld_req_i/ld_addr_i               load read request
//   st_req_i/st_addr_i/st_data_i     store request
//   *_gnt_o                          one-cycle acceptance pulse (ACCESS cycle)
//   *_done_o                         one-cycle completion pulse (RESP cycle)
//   rdata_o                          last read data, valid with read done
//   mem_en_o/mem_we_o                memory strobe / write select
//   mem_addr_o/mem_wdata_o           memory address / write data (0 when idle)
//   mem_rdata_i                      memory read data, RD_LAT cycles after strobe
//   busy_o                           high outside IDLE
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fet_req_i,
  input  logic [ADDR_W-1:0] fet_addr_i,
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic              st_req_i,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [31:0]       st_data_i,
  output logic              fet_gnt_o,
  output logic              ld_gnt_o,
  output logic              st_gnt_o,
  output logic              fet_done_o,
  output logic              ld_done_o,
  output logic              st_done_o,
  output logic [31:0]       rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("mem_arbiter: RD_LAT must be in 1..4");
  end

  state_e            state_q, state_d;
  req_id_e           id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [2:0]        cnt_q, cnt_d;

  logic [NUM_REQ-1:0] req_vec;
  logic               pick_valid;
  req_id_e            pick_id;
  logic [ADDR_W-1:0]  pick_addr;

  assign req_vec = {st_req_i, ld_req_i, fet_req_i};

`ifdef MEM_ARB_RR_EN
  req_id_e rr_ptr_q, rr_ptr_d;
`endif

  mem_arb_pick u_pick (
    .req_i   (req_vec),
`ifdef MEM_ARB_RR_EN
    .ptr_i   (rr_ptr_q),
`endif
    .valid_o (pick_valid),
    .id_o    (pick_id)
  );

  always_comb begin
    case (pick_id)
      REQ_ST:  pick_addr = st_addr_i;
      REQ_LD:  pick_addr = ld_addr_i;
      default: pick_addr = fet_addr_i;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
`ifdef MEM_ARB_RR_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Requests are only looked at here; anything raised and dropped
        // while busy is simply never seen.
        if (pick_valid) begin
          state_d = S_ACCESS;
          id_d    = pick_id;
          addr_d  = pick_addr;
          wdata_d = (pick_id == REQ_ST) ? st_data_i : 32'h0;
`ifdef MEM_ARB_RR_EN
          // Winner drops to lowest priority next round.
          rr_ptr_d = next_id(pick_id);
`endif
        end
      end
      S_ACCESS: begin
        if (id_q == REQ_ST) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 3'(RD_LAT);
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd1) begin
          state_d = S_RESP;
          cnt_d   = 3'd0;
          rdata_d = mem_rdata_i;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;  // S_RESP always returns to IDLE
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      id_q     <= REQ_FET;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      cnt_q    <= 3'd0;
`ifdef MEM_ARB_RR_EN
      rr_ptr_q <= REQ_FET;
`endif
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
`ifdef MEM_ARB_RR_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  logic in_access, in_resp;
  assign in_access = (state_q == S_ACCESS);
  assign in_resp   = (state_q == S_RESP);

  assign fet_gnt_o   = in_access && (id_q == REQ_FET);
  assign ld_gnt_o    = in_access && (id_q == REQ_LD);
  assign st_gnt_o    = in_access && (id_q == REQ_ST);
  assign fet_done_o  = in_resp && (id_q == REQ_FET);
  assign ld_done_o   = in_resp && (id_q == REQ_LD);
  assign st_done_o   = in_resp && (id_q == REQ_ST);
  assign mem_en_o    = in_access;
  assign mem_we_o    = in_access && (id_q == REQ_ST);
  assign mem_addr_o  = in_access ? addr_q : '0;
  assign mem_wdata_o = in_access ? wdata_q : 32'h0;
  assign rdata_o     = rdata_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Two instances share the request inputs:
// dut_a uses RD_LAT=1, dut_b uses RD_LAT=4. Each has its own memory model
// that registers read data on the strobe edge and holds it.
// Round-robin expectations apply when MEM_ARB_RR_EN is defined.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        fet_req, ld_req, st_req;
  logic [31:0] fet_addr, ld_addr, st_addr, st_data;

  logic        fet_gnt_a, ld_gnt_a, st_gnt_a, fet_done_a, ld_done_a, st_done_a;
  logic        mem_en_a, mem_we_a, busy_a;
  logic [31:0] rdata_a, mem_addr_a, mem_wdata_a, mem_rd_a;

  logic        fet_gnt_b, ld_gnt_b, st_gnt_b, fet_done_b, ld_done_b, st_done_b;
  logic        mem_en_b, mem_we_b, busy_b;
  logic [31:0] rdata_b, mem_addr_b, mem_wdata_b, mem_rd_b;

  logic [2:0] gnt_vec_a, done_vec_a, gnt_vec_b, done_vec_b;
  assign gnt_vec_a  = {st_gnt_a, ld_gnt_a, fet_gnt_a};
  assign done_vec_a = {st_done_a, ld_done_a, fet_done_a};
  assign gnt_vec_b  = {st_gnt_b, ld_gnt_b, fet_gnt_b};
  assign done_vec_b = {st_done_b, ld_done_b, fet_done_b};

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  mem_arbiter #(.RD_LAT(1), .ADDR_W(32)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .fet_req_i(fet_req), .fet_addr_i(fet_addr),
    .ld_req_i(ld_req), .ld_addr_i(ld_addr),
    .st_req_i(st_req), .st_addr_i(st_addr), .st_data_i(st_data),
    .fet_gnt_o(fet_gnt_a), .ld_gnt_o(ld_gnt_a), .st_gnt_o(st_gnt_a),
    .fet_done_o(fet_done_a), .ld_done_o(ld_done_a), .st_done_o(st_done_a),
    .rdata_o(rdata_a), .mem_en_o(mem_en_a), .mem_we_o(mem_we_a),
    .mem_addr_o(mem_addr_a), .mem_wdata_o(mem_wdata_a),
    .mem_rdata_i(mem_rd_a), .busy_o(busy_a)
  );

  mem_arbiter #(.RD_LAT(4), .ADDR_W(32)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .fet_req_i(fet_req), .fet_addr_i(fet_addr),
    .ld_req_i(ld_req), .ld_addr_i(ld_addr),
    .st_req_i(st_req), .st_addr_i(st_addr), .st_data_i(st_data),
    .fet_gnt_o(fet_gnt_b), .ld_gnt_o(ld_gnt_b), .st_gnt_o(st_gnt_b),
    .fet_done_o(fet_done_b), .ld_done_o(ld_done_b), .st_done_o(st_done_b),
    .rdata_o(rdata_b), .mem_en_o(mem_en_b), .mem_we_o(mem_we_b),
    .mem_addr_o(mem_addr_b), .mem_wdata_o(mem_wdata_b),
    .mem_rdata_i(mem_rd_b), .busy_o(busy_b)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : {a[15:0], 16'hC0DE};
  endfunction

  always @(posedge clk) begin
    if (mem_en_a && !mem_we_a) mem_rd_a <= mem_fn(mem_addr_a);
    if (mem_en_b && !mem_we_b) mem_rd_b <= mem_fn(mem_addr_b);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_gnt_a(output logic [2:0] g);
    int n = 0;
    g = gnt_vec_a;
    while (g == 3'b000 && n < 20) begin
      tick();
      n++;
      g = gnt_vec_a;
    end
    check("wait_gnt_a", 32'(g != 3'b000), 32'd1);
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (busy_a && n < 30) begin
      tick();
      n++;
    end
    check("wait_idle_a", 32'(busy_a), 32'd0);
  endtask

  task automatic wait_idle_b();
    int n = 0;
    while (busy_b && n < 30) begin
      tick();
      n++;
    end
    check("wait_idle_b", 32'(busy_b), 32'd0);
  endtask

  task automatic wait_ld_gnt_b();
    int n = 0;
    while (!ld_gnt_b && n < 20) begin
      tick();
      n++;
    end
    check("wait_ld_gnt_b", 32'(ld_gnt_b), 32'd1);
  endtask

  logic [2:0] g;
  int         prev_cyc;
  int         n_ld_gnt, n_ld_done, n_fet_done;
  logic [2:0] exp_fix [3] = '{3'b100, 3'b010, 3'b001};
  int         exp_gap [3] = '{0, 3, 4};
  logic [2:0] exp_rr  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    rst = 1'b1;
    fet_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    fet_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0;

    // Reset state
    tick();
    tick();
    check("rst_busy",  32'(busy_a), 32'd0);
    check("rst_gnt",   32'(gnt_vec_a), 32'd0);
    check("rst_done",  32'(done_vec_a), 32'd0);
    check("rst_mem_en", 32'({mem_en_a, mem_we_a}), 32'd0);
    check("rst_addr",  mem_addr_a, 32'h0);
    check("rst_rdata", rdata_a, 32'h0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy_a), 32'd0);

    // Single fetch, RD_LAT=1
    fet_req = 1'b1; fet_addr = 32'h100;
    tick();
    check("fet_gnt_vec", 32'(gnt_vec_a), 32'b001);
    check("fet_mem_en", 32'(mem_en_a), 32'd1);
    check("fet_mem_we", 32'(mem_we_a), 32'd0);
    check("fet_mem_addr", mem_addr_a, 32'h100);
    check("fet_busy", 32'(busy_a), 32'd1);
    fet_req = 1'b0; fet_addr = 32'hFFF;
    tick();
    check("fet_wait_en", 32'(mem_en_a), 32'd0);
    check("fet_wait_gnt", 32'(gnt_vec_a), 32'd0);
    check("fet_wait_done", 32'(done_vec_a), 32'd0);
    tick();
    check("fet_done_vec", 32'(done_vec_a), 32'b001);
    check("fet_rdata", rdata_a, 32'h0000_0013);
    tick();
    check("fet_back_idle", 32'(busy_a), 32'd0);
    check("fet_done_clr", 32'(done_vec_a), 32'd0);
    check("fet_rdata_hold", rdata_a, 32'h0000_0013);

    // Single store
    st_req = 1'b1; st_addr = 32'h2000; st_data = 32'hDEADBEEF;
    tick();
    check("st_gnt_vec", 32'(gnt_vec_a), 32'b100);
    check("st_mem_we", 32'(mem_we_a), 32'd1);
    check("st_mem_addr", mem_addr_a, 32'h2000);
    check("st_mem_wdata", mem_wdata_a, 32'hDEADBEEF);
    st_req = 1'b0; st_data = 32'h1234_5678;
    tick();
    check("st_done_vec", 32'(done_vec_a), 32'b100);
    check("st_resp_en", 32'(mem_en_a), 32'd0);
    check("st_resp_wdata", mem_wdata_a, 32'h0);
    check("st_rdata_keep", rdata_a, 32'h0000_0013);
    tick();
    check("st_back_idle", 32'(busy_a), 32'd0);

`ifndef MEM_ARB_RR_EN
    // Fixed priority, all three held until granted
    st_req = 1'b1; st_addr = 32'h2100; st_data = 32'hA5A5A5A5;
    ld_req = 1'b1; ld_addr = 32'h1100;
    fet_req = 1'b1; fet_addr = 32'h0200;
    prev_cyc = cyc;
    for (int i = 0; i < 3; i++) begin
      wait_gnt_a(g);
      check($sformatf("fix_order%0d", i), 32'(g), 32'(exp_fix[i]));
      if (i > 0) check($sformatf("fix_gap%0d", i), 32'(cyc - prev_cyc), 32'(exp_gap[i]));
      if (i == 0) check("fix_st_wdata", mem_wdata_a, 32'hA5A5A5A5);
      prev_cyc = cyc;
      if (g[2]) st_req = 1'b0;
      if (g[1]) ld_req = 1'b0;
      if (g[0]) fet_req = 1'b0;
      tick();
    end
`else
    // Round-robin, all three held continuously
    st_req = 1'b1; st_addr = 32'h2100; st_data = 32'hA5A5A5A5;
    ld_req = 1'b1; ld_addr = 32'h1100;
    fet_req = 1'b1; fet_addr = 32'h0200;
    for (int i = 0; i < 4; i++) begin
      wait_gnt_a(g);
      check($sformatf("rr_order%0d", i), 32'(g), 32'(exp_rr[i]));
      tick();
    end
    st_req = 1'b0; ld_req = 1'b0; fet_req = 1'b0;
`endif
    wait_idle_a();

    // Load pulsed while busy and dropped before IDLE
    fet_req = 1'b1; fet_addr = 32'h400;
    wait_gnt_a(g);
    check("pulse_fet_gnt", 32'(g), 32'b001);
    fet_req = 1'b0;
    tick();
    ld_req = 1'b1; ld_addr = 32'h500;
    n_ld_gnt = 0; n_ld_done = 0; n_fet_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) ld_req = 1'b0;
      if (ld_gnt_a)   n_ld_gnt++;
      if (ld_done_a)  n_ld_done++;
      if (fet_done_a) n_fet_done++;
    end
    check("pulse_ld_gnt", 32'(n_ld_gnt), 32'd0);
    check("pulse_ld_done", 32'(n_ld_done), 32'd0);
    check("pulse_fet_done", 32'(n_fet_done), 32'd1);

    // RD_LAT=4: reset during WAIT discards the load
    wait_idle_b();
    wait_idle_a();
    ld_req = 1'b1; ld_addr = 32'h300;
    wait_ld_gnt_b();
    ld_req = 1'b0;
    tick();
    tick();
    check("b_in_wait", 32'(busy_b), 32'd1);
    rst = 1'b1;
    tick();
    check("b_rst_busy", 32'(busy_b), 32'd0);
    check("b_rst_gnt", 32'(gnt_vec_b), 32'd0);
    check("b_rst_done", 32'(done_vec_b), 32'd0);
    check("b_rst_mem", 32'({mem_en_b, mem_we_b}), 32'd0);
    check("b_rst_addr", mem_addr_b, 32'h0);
    check("b_rst_rdata", rdata_b, 32'h0);
    rst = 1'b0;
    n_ld_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ld_done_b) n_ld_done++;
    end
    check("b_discarded_done", 32'(n_ld_done), 32'd0);

    // Fresh load on dut_b is served with the full latency
    ld_req = 1'b1; ld_addr = 32'h300;
    wait_ld_gnt_b();
    check("b_ld_addr", mem_addr_b, 32'h300);
    ld_req = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("b_ld_done_t%0d", i), 32'(ld_done_b), (i == 5) ? 32'd1 : 32'd0);
    end
    check("b_ld_rdata", rdata_b, 32'h0300_C0DE);
    tick();
    check("b_back_idle", 32'(busy_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1, memory read latency in cycles (legal 1..4).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 fet_req_i / fet_addr_i  in  1 / ADDR_W  fetch read request, address.
REQ-006 ld_req_i / ld_addr_i  in  1 / ADDR_W  load read request, address.
REQ-007 st_req_i / st_addr_i / st_data_i  in  1 / ADDR_W / 32  store request, address, write data.
REQ-008 fet_gnt_o, ld_gnt_o, st_gnt_o  out  1 each  one-cycle acceptance pulse per requester.
REQ-009 fet_done_o, ld_done_o, st_done_o  out  1 each  one-cycle completion pulse per requester.
REQ-010 rdata_o  out  32  read data, valid in the fet_done_o/ld_done_o cycle.
REQ-011 mem_en_o / mem_we_o  out  1 / 1  memory access strobe, write select.
REQ-012 mem_addr_o / mem_wdata_o  out  ADDR_W / 32  memory address, write data.
REQ-013 mem_rdata_i  in  32  memory read data, valid RD_LAT cycles after mem_en_o.
REQ-014 busy_o  out  1  high in every state except IDLE.

Function
REQ-015 FSM states IDLE, ACCESS, WAIT, RESP; exactly one transaction in flight.
REQ-016 IDLE: any req sampled high at edge k -> winner, address, data latched; ACCESS at k; winner's gnt_o high only during ACCESS cycle.
REQ-017 ACCESS: mem_en_o=1 for exactly one cycle, mem_we_o=1 only for store, mem_addr_o/mem_wdata_o = latched values; 0 outside ACCESS.
REQ-018 Store: ACCESS -> RESP; st_done_o in RESP cycle (edge k+1); total 3 cycles back to IDLE.
REQ-019 Read: ACCESS -> WAIT for exactly RD_LAT cycles (down-counter, 3 bits) -> RESP; mem_rdata_i captured into rdata_o on the WAIT->RESP edge (k+1+RD_LAT).
REQ-020 rdata_o holds last read value until the next read RESP; stores never modify it.
REQ-021 RESP -> IDLE unconditionally; no back-to-back grant from RESP (one idle arbitration cycle).
REQ-022 Requesters hold req/addr/data until gnt; changes after gnt ignored; req dropped before gnt is never served.
REQ-023 Requests arriving outside IDLE are not queued; they win only if still high in IDLE.
REQ-024 Fixed priority (default): store > load > fetch; simultaneous all three -> store granted.
REQ-025 At most one gnt_o and one done_o high in any cycle; done_o goes only to the latched winner.

Reset
REQ-026 rst_i high at an edge: state IDLE, counter 0, all gnt_o/done_o/mem_en_o/mem_we_o/busy_o 0, mem_addr_o/mem_wdata_o/rdata_o 0, RR pointer to fetch.
REQ-027 Reset mid-transaction discards it: no done_o is ever issued for it.

Configuration
REQ-028 Macro MEM_ARB_RR_EN defined: round-robin among the three requesters, order fetch->load->store, most recently granted gets lowest priority on next arbitration.
REQ-029 Macro MEM_ARB_RR_EN undefined: fixed priority per REQ-024, no pointer register present.

Structure
REQ-030 Package mem_arb_pkg holds state encoding, requester IDs (FET=0, LD=1, ST=2), RD_LAT bounds.
REQ-031 One sub-module mem_arb_pick: combinational 3-request picker (fixed or RR per macro), pointer register kept in mem_arbiter.
REQ-032 RD_LAT outside 1..4 is a elaboration-time error.

Verification
REQ-033 RD_LAT=1; fet_req_i with addr 0x100, mem returns 0x00000013 -> fet_gnt_o at ACCESS, mem_en_o one cycle, fet_done_o and rdata_o=0x00000013 two edges later.
REQ-034 st_req_i addr 0x2000 data 0xDEADBEEF -> mem_we_o=1, mem_wdata_o=0xDEADBEEF in ACCESS, st_done_o next cycle, rdata_o unchanged.
REQ-035 Fixed priority: all three req same cycle, held -> grant order store, load, fetch, each separated by RESP+IDLE.
REQ-036 MEM_ARB_RR_EN, all three held continuously -> grants rotate fetch, load, store, fetch; none starved.
REQ-037 RD_LAT=4; rst_i asserted during WAIT -> all outputs 0 next cycle, no ld_done_o, fresh ld_req_i then served normally.
REQ-038 ld_req_i pulsed while busy and dropped before IDLE -> never granted; no ld_done_o.
